serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequencer for the bit-serial CIM adder. Walks N bit-planes of operands A and B, LSB first.
- Per bit: issues an array row read, waits for the AND/XOR result, then strobes carry update and sum writeback.
- Sits between the host command interface and the array/serial-adder datapath. Drives the adder's carry load/update controls and the array read/write strobes.

Parameters:
- LANES, 32, column count; width of carry_out.
- ADDR_W, 8, row address width.
- MAX_BITS, 32, largest operand bit count accepted.

Ports:
- sys_clk_in  in  1  system clock
- sys_reset_n_in  in  1  asynchronous active-low reset
- start_in  in  1  command strobe, sampled in IDLE only
- abort_in  in  1  synchronous abort
- op_sub_in  in  1  1 = A-B, 0 = A+B; sampled with start_in
- bits_in  in  6  operand bit count; sampled with start_in
- a_base_in / b_base_in / d_base_in  in  ADDR_W each  LSB row of A, B and destination; sampled with start_in
- busy_out  out  1  high from accept until return to IDLE
- done_out  out  1  one-cycle completion pulse
- rd_en_out  out  1  array dual-row read request
- rd_addr_a_out / rd_addr_b_out  out  ADDR_W each  rows for the current bit
- invert_b_out  out  1  array inverts B row; held for a whole subtract
- rd_valid_in  in  1  array AND/XOR result valid this cycle
- load_carry_out  out  1  to adder carry load
- update_carry_out  out  1  to adder carry update
- carry_out  out  LANES  carry preset value
- wr_en_out  out  1  write adder sum to array
- wr_addr_out  out  ADDR_W  destination row

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; bit index 0.
- IDLE: start_in=1 latches all command inputs and moves to LOAD.
  - effective bits = min(bits_in, MAX_BITS).
  - If effective bits = 0: go directly to DONE; no array activity.
- LOAD (1 cycle):
  - load_carry_out=1.
  - carry_out = all ones if sub, else all zeros.
  - invert_b_out = sub, held until IDLE.
- READ (1 cycle):
  - rd_en_out=1.
  - rd_addr_a_out = a_base+i, rd_addr_b_out = b_base+i, both modulo 2^ADDR_W (wrap allowed).
- WAIT: hold addresses; stay until rd_valid_in=1.
  - If rd_valid_in is already 1 in the READ cycle, go straight to WRITE.
  - rd_valid_in outside READ/WAIT is ignored.
- WRITE (1 cycle):
  - wr_en_out=1, wr_addr_out = d_base+i (wrapped), update_carry_out=1 in the same cycle.
  - The sum is written using the old carry; the carry register advances at the clock edge.
  - Then i++. If i = effective bits go to DONE, else READ.
- DONE (1 cycle): done_out=1, busy_out=1; then IDLE.
- busy_out=1 in every state except IDLE.
- Latency with 1-cycle read return: 3 cycles per bit. done_out is asserted 3N+2 cycles after the start edge.
- start_in while busy: ignored; no queueing.
- abort_in:
  - Any non-IDLE state goes to IDLE next cycle; no done pulse; all strobes drop.
  - The carry register is left as is; the next LOAD overwrites it.
  - abort_in and start_in together in IDLE: abort wins, command dropped.
- Control strobes are mutually exclusive: at most one of load_carry_out, rd_en_out, wr_en_out is high per cycle.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.

Optional Feature:
- Macro: SERIAL_ADD_CTRL_CARRY_WB_EN.
- When defined:
  - After the last WRITE, add state CARRY_WB before DONE.
  - CARRY_WB asserts new output zero_operands_out=1 (array forces AND/XOR to 0, so sum = carry) with wr_en_out=1 and wr_addr_out = d_base+N (wrapped).
  - No carry update in that cycle.
  - Latency becomes 3N+3.
- When undefined: no zero_operands_out port, no CARRY_WB state.

Test Plan:
- Add, N=4, A=5, B=3, bases 0/8/16, rd_valid 1-cycle latency -> writes to rows 16..19 carry sum bits 0,0,0,1; done_out at start+14; busy_out low the cycle after.
- Subtract, N=8, A=10, B=3 -> load_carry_out with carry_out all ones; invert_b_out high throughout; 8 writes to rows d..d+7; done_out once.
- N=2, rd_valid delayed 5 cycles each bit -> WAIT holds addresses; no duplicate rd_en_out; done_out at start+16.
- a_base=0xFE, N=4 -> read rows FE, FF, 00, 01; start_in pulsed mid-op is ignored.
- abort_in asserted in the WRITE of bit 1 -> busy_out low next cycle, no done_out, no further wr_en_out; a subsequent start runs normally.
- bits_in=0 -> done_out 1 cycle after start, zero strobes. bits_in=40 with MAX_BITS=32 -> exactly 32 writes.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Sequencer for the bit-serial compute-in-memory adder. It accepts one add or
// subtract command, then processes the operand bit-planes from LSB to MSB. For
// each bit it issues a dual-row array read, waits for the array's AND/XOR
// result, and then writes back the sum while strobing a carry update. The
// adder carry is preset in a single LOAD cycle. For a subtract, that preset is
// all ones and the array's B row is inverted (A + ~B + 1).
//
// Optional build macro: SERIAL_ADD_CTRL_CARRY_WB_EN
//   When this macro is defined, a CARRY_WB state follows the last bit. In that
//   state the final carry is written to row d_base+N. The array is told to zero
//   its operands through zero_operands_out, so the adder's sum equals the
//   carry. This adds one cycle of latency. When the macro is undefined, the
//   port and the state do not exist.
//
// Ports
//   sys_clk_in, sys_reset_n_in       clock, asynchronous active-low reset
//   start_in, abort_in               command strobe (IDLE only), abort
//   op_sub_in, bits_in               subtract select, operand bit count
//   a_base_in, b_base_in, d_base_in  LSB rows of A, B and destination
//   busy_out, done_out               busy level, one-cycle completion pulse
//   rd_en_out, rd_addr_a/b_out       array dual-row read request and rows
//   invert_b_out                     array inverts B row (whole subtract)
//   rd_valid_in                      array AND/XOR result valid
//   load_carry_out, carry_out        adder carry preset strobe and value
//   update_carry_out                 adder carry advance strobe
//   wr_en_out, wr_addr_out           sum writeback strobe and row
//   zero_operands_out                (macro only) force array operands to 0
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int LANES    = 32,
    parameter int ADDR_W   = 8,
    parameter int MAX_BITS = 32
) (
    input  logic              sys_clk_in,
    input  logic              sys_reset_n_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic              op_sub_in,
    input  logic [5:0]        bits_in,
    input  logic [ADDR_W-1:0] a_base_in,
    input  logic [ADDR_W-1:0] b_base_in,
    input  logic [ADDR_W-1:0] d_base_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_a_out,
    output logic [ADDR_W-1:0] rd_addr_b_out,
    output logic              invert_b_out,
    input  logic              rd_valid_in,
    output logic              load_carry_out,
    output logic              update_carry_out,
    output logic [LANES-1:0]  carry_out,
`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
    output logic              zero_operands_out,
`endif
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out
);

    // Wide enough to hold MAX_BITS itself (the terminal bit count).
    localparam int IDX_W = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_CARRY_WB,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic              sub_reg;
    logic [IDX_W-1:0]  bits_eff_reg;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic [ADDR_W-1:0] a_base_reg;
    logic [ADDR_W-1:0] b_base_reg;
    logic [ADDR_W-1:0] d_base_reg;

    logic [IDX_W-1:0]  bits_eff_next;
    logic [IDX_W-1:0]  bit_idx_next;

    // Clamp the requested bit count to MAX_BITS. The comparison is done in int
    // so that it holds for any MAX_BITS/IDX_W combination.
    always_comb begin
        bits_eff_next = '0;
        if (int'(bits_in) > MAX_BITS) begin
            bits_eff_next = IDX_W'(MAX_BITS);
        end else begin
            bits_eff_next = IDX_W'(bits_in);
        end
        bit_idx_next = bit_idx_reg + IDX_W'(1);
    end

    // All outputs are registered. Each transition sets the outputs that belong
    // to the state being entered. Strobes default low every cycle, so at most
    // one of load/read/write can be high at any time.
    always_ff @(posedge sys_clk_in or negedge sys_reset_n_in) begin
        if (!sys_reset_n_in) begin
            state_reg         <= ST_IDLE;
            sub_reg           <= 1'b0;
            bits_eff_reg      <= '0;
            bit_idx_reg       <= '0;
            a_base_reg        <= '0;
            b_base_reg        <= '0;
            d_base_reg        <= '0;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            rd_en_out         <= 1'b0;
            rd_addr_a_out     <= '0;
            rd_addr_b_out     <= '0;
            invert_b_out      <= 1'b0;
            load_carry_out    <= 1'b0;
            update_carry_out  <= 1'b0;
            carry_out         <= '0;
`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
            zero_operands_out <= 1'b0;
`endif
            wr_en_out         <= 1'b0;
            wr_addr_out       <= '0;
        end else begin
            done_out          <= 1'b0;
            rd_en_out         <= 1'b0;
            load_carry_out    <= 1'b0;
            update_carry_out  <= 1'b0;
            carry_out         <= '0;
`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
            zero_operands_out <= 1'b0;
`endif
            wr_en_out         <= 1'b0;

            if (abort_in) begin
                // Abort also wins over a start that arrives in IDLE. The
                // adder's carry is not touched; the next LOAD presets it.
                state_reg    <= ST_IDLE;
                busy_out     <= 1'b0;
                invert_b_out <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_in) begin
                            sub_reg      <= op_sub_in;
                            bits_eff_reg <= bits_eff_next;
                            a_base_reg   <= a_base_in;
                            b_base_reg   <= b_base_in;
                            d_base_reg   <= d_base_in;
                            bit_idx_reg  <= '0;
                            busy_out     <= 1'b1;
                            if (bits_eff_next == '0) begin
                                state_reg <= ST_DONE;
                                done_out  <= 1'b1;
                            end else begin
                                state_reg      <= ST_LOAD;
                                load_carry_out <= 1'b1;
                                carry_out      <= {LANES{op_sub_in}};
                                invert_b_out   <= op_sub_in;
                            end
                        end
                    end

                    ST_LOAD: begin
                        state_reg     <= ST_READ;
                        rd_en_out     <= 1'b1;
                        rd_addr_a_out <= a_base_reg;
                        rd_addr_b_out <= b_base_reg;
                    end

                    // A result that is already valid in the READ cycle skips
                    // WAIT. The read addresses stay on the outputs meanwhile.
                    ST_READ, ST_WAIT: begin
                        if (rd_valid_in) begin
                            state_reg        <= ST_WRITE;
                            wr_en_out        <= 1'b1;
                            update_carry_out <= 1'b1;
                            wr_addr_out      <= d_base_reg + ADDR_W'(bit_idx_reg);
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end

                    ST_WRITE: begin
                        bit_idx_reg <= bit_idx_next;
                        if (bit_idx_next == bits_eff_reg) begin
`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
                            state_reg         <= ST_CARRY_WB;
                            wr_en_out         <= 1'b1;
                            zero_operands_out <= 1'b1;
                            wr_addr_out       <= d_base_reg + ADDR_W'(bits_eff_reg);
`else
                            state_reg <= ST_DONE;
                            done_out  <= 1'b1;
`endif
                        end else begin
                            state_reg     <= ST_READ;
                            rd_en_out     <= 1'b1;
                            rd_addr_a_out <= a_base_reg + ADDR_W'(bit_idx_next);
                            rd_addr_b_out <= b_base_reg + ADDR_W'(bit_idx_next);
                        end
                    end

`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
                    ST_CARRY_WB: begin
                        state_reg <= ST_DONE;
                        done_out  <= 1'b1;
                    end
`endif

                    ST_DONE: begin
                        state_reg    <= ST_IDLE;
                        busy_out     <= 1'b0;
                        invert_b_out <= 1'b0;
                    end

                    default: begin
                        state_reg    <= ST_IDLE;
                        busy_out     <= 1'b0;
                        invert_b_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Intentionally unused: the sub flag is captured for completeness; its
    // visible effects are carry_out/invert_b_out set on entering LOAD.
    logic unused_sub;
    assign unused_sub = sub_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl. A small array/adder model reacts to the
// controller's strobes: operand rows come from per-test A/B values, and sums
// are written into a result memory. A responder returns rd_valid after a
// programmable delay. Each test task starts commands and compares the results
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int LANES    = 32;
    localparam int ADDR_W   = 8;
    localparam int MAX_BITS = 32;
`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic              sys_clk_in     = 1'b0;
    logic              sys_reset_n_in = 1'b0;
    logic              start_in       = 1'b0;
    logic              abort_in       = 1'b0;
    logic              op_sub_in      = 1'b0;
    logic [5:0]        bits_in        = '0;
    logic [ADDR_W-1:0] a_base_in      = '0;
    logic [ADDR_W-1:0] b_base_in      = '0;
    logic [ADDR_W-1:0] d_base_in      = '0;
    logic              rd_valid_in    = 1'b0;
    logic              busy_out, done_out, rd_en_out, invert_b_out;
    logic              load_carry_out, update_carry_out, wr_en_out;
    logic [ADDR_W-1:0] rd_addr_a_out, rd_addr_b_out, wr_addr_out;
    logic [LANES-1:0]  carry_out;
    logic              zops;

    serial_add_ctrl #(.LANES(LANES), .ADDR_W(ADDR_W), .MAX_BITS(MAX_BITS)) dut (
        .sys_clk_in       (sys_clk_in),
        .sys_reset_n_in   (sys_reset_n_in),
        .start_in         (start_in),
        .abort_in         (abort_in),
        .op_sub_in        (op_sub_in),
        .bits_in          (bits_in),
        .a_base_in        (a_base_in),
        .b_base_in        (b_base_in),
        .d_base_in        (d_base_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .rd_en_out        (rd_en_out),
        .rd_addr_a_out    (rd_addr_a_out),
        .rd_addr_b_out    (rd_addr_b_out),
        .invert_b_out     (invert_b_out),
        .rd_valid_in      (rd_valid_in),
        .load_carry_out   (load_carry_out),
        .update_carry_out (update_carry_out),
        .carry_out        (carry_out),
`ifdef SERIAL_ADD_CTRL_CARRY_WB_EN
        .zero_operands_out(zops),
`endif
        .wr_en_out        (wr_en_out),
        .wr_addr_out      (wr_addr_out)
    );
`ifndef SERIAL_ADD_CTRL_CARRY_WB_EN
    assign zops = 1'b0;
`endif

    always #5 sys_clk_in = ~sys_clk_in;

    int cyc = 0;
    always @(posedge sys_clk_in) cyc <= cyc + 1;

    // Per-test configuration, written only by the test tasks.
    logic [63:0]       a_val_v = '0, b_val_v = '0;
    logic [ADDR_W-1:0] a_base_v = '0, b_base_v = '0;
    logic              sub_expect = 1'b0;
    int                rd_delay = 1;

    // Monitor state, written only by the monitor process.
    int excl_viol = 0, hold_viol = 0, upd_viol = 0, inv_viol = 0;
    int load_cnt = 0, done_cnt = 0;
    logic [LANES-1:0] last_carry = '0;
    int rd_q[$];
    int wr_q[$];
    logic [LANES-1:0] res_mem [256];
    logic [LANES-1:0] carry_m = '0, opa_m = '0, opb_m = '0;
    logic [ADDR_W-1:0] hold_a = '0, hold_b = '0;
    logic holding = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic logic opbit(input logic [63:0] v, input logic [7:0] base,
                                   input logic [7:0] addr);
        logic [7:0] off;
        off = addr - base;
        return (off < 8'd64) ? v[off[5:0]] : 1'b0;
    endfunction

    // Returns rd_valid rd_delay cycles after the READ cycle.
    int pend = 0;
    always @(negedge sys_clk_in) begin
        if (rd_en_out) begin
            pend = rd_delay;
            rd_valid_in = (rd_delay == 0);
        end else if (pend > 0) begin
            pend--;
            rd_valid_in = (pend == 0);
        end else begin
            rd_valid_in = 1'b0;
        end
    end

    // Array + bit-serial adder model and strobe monitor.
    always @(negedge sys_clk_in) begin
        int n;
        n = int'(load_carry_out) + int'(rd_en_out) + int'(wr_en_out);
        if (n > 1) excl_viol++;
        if (!busy_out) holding = 1'b0;
        if (load_carry_out) begin
            load_cnt++;
            last_carry = carry_out;
            carry_m    = carry_out;
        end
        if (rd_en_out) begin
            rd_q.push_back(int'(rd_addr_a_out));
            opa_m   = {LANES{opbit(a_val_v, a_base_v, rd_addr_a_out)}};
            opb_m   = {LANES{opbit(b_val_v, b_base_v, rd_addr_b_out)}} ^ {LANES{invert_b_out}};
            hold_a  = rd_addr_a_out;
            hold_b  = rd_addr_b_out;
            holding = 1'b1;
        end else if (holding && (rd_addr_a_out !== hold_a || rd_addr_b_out !== hold_b)) begin
            hold_viol++;
        end
        if (wr_en_out) begin
            holding = 1'b0;
            wr_q.push_back(int'(wr_addr_out));
            if (zops) begin
                res_mem[wr_addr_out] = carry_m;
            end else begin
                res_mem[wr_addr_out] = opa_m ^ opb_m ^ carry_m;
                if (!update_carry_out) upd_viol++;
            end
            if (update_carry_out)
                carry_m = (opa_m & opb_m) | (opa_m & carry_m) | (opb_m & carry_m);
        end else if (update_carry_out) begin
            upd_viol++;
        end
        if (zops && update_carry_out) upd_viol++;
        if (sub_expect && busy_out && !invert_b_out) inv_viol++;
        if (done_out) done_cnt++;
    end

    // Issue one command; called on a negedge, returns on the next negedge.
    task automatic begin_op(input logic sub, input logic [5:0] bits,
                            input logic [7:0] ab, input logic [7:0] bb, input logic [7:0] db,
                            input logic [63:0] av, input logic [63:0] bv,
                            input int dly, output int s);
        a_val_v = av; b_val_v = bv; a_base_v = ab; b_base_v = bb;
        sub_expect = sub; rd_delay = dly;
        op_sub_in = sub; bits_in = bits;
        a_base_in = ab; b_base_in = bb; d_base_in = db;
        start_in = 1'b1;
        s = cyc;
        @(negedge sys_clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < budget; k++) begin
            if (done_out) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
            @(negedge sys_clk_in);
        end
    endtask

    task automatic test_reset();
        sys_reset_n_in = 1'b0;
        repeat (3) @(negedge sys_clk_in);
        total_cnt++;
        if ({busy_out, done_out, rd_en_out, rd_addr_a_out, rd_addr_b_out, invert_b_out,
             load_carry_out, update_carry_out, carry_out, wr_en_out, wr_addr_out} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        else pass_cnt++;
        sys_reset_n_in = 1'b1;
        repeat (2) @(negedge sys_clk_in);
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy_out);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int s, at, w0, r0, d0, l0;
        bit seen;
        logic [7:0] exp_v;
        exp_v = 8'd8;  // 5 + 3
        w0 = wr_q.size(); r0 = rd_q.size(); d0 = done_cnt; l0 = load_cnt;
        begin_op(1'b0, 6'd4, 8'd0, 8'd8, 8'd16, 64'd5, 64'd3, 1, s);
        wait_done(80, seen, at);
        total_cnt++;
        if (!seen || at != s + 14 + WB)
            $display("FAIL add_done_cycle: got %0d expected %0d", at - s, 14 + WB);
        else pass_cnt++;
        @(negedge sys_clk_in);
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL add_busy_after: got %b expected 0", busy_out);
        else pass_cnt++;
        total_cnt++;
        if (wr_q.size() - w0 != 4 + WB)
            $display("FAIL add_write_count: got %0d expected %0d", wr_q.size() - w0, 4 + WB);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (wr_q[w0 + k] != 16 + k || rd_q[r0 + k] != k)
                $display("FAIL add_rows bit%0d: wr %0d rd %0d expected wr %0d rd %0d",
                         k, wr_q[w0 + k], rd_q[r0 + k], 16 + k, k);
            else pass_cnt++;
            total_cnt++;
            if (res_mem[16 + k] !== {LANES{exp_v[k]}})
                $display("FAIL add_sum bit%0d: got %h expected %h", k, res_mem[16 + k], {LANES{exp_v[k]}});
            else pass_cnt++;
        end
        total_cnt++;
        if (load_cnt - l0 != 1 || last_carry !== '0)
            $display("FAIL add_load: got count %0d carry %h expected 1 and 0", load_cnt - l0, last_carry);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL add_done_count: got %0d expected 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_sub();
        int s, at, w0, d0;
        bit seen;
        logic [7:0] exp_v;
        exp_v = 8'd7;  // 10 - 3
        w0 = wr_q.size(); d0 = done_cnt;
        begin_op(1'b1, 6'd8, 8'h60, 8'h70, 8'h80, 64'd10, 64'd3, 1, s);
        wait_done(80, seen, at);
        total_cnt++;
        if (!seen || at != s + 26 + WB)
            $display("FAIL sub_done_cycle: got %0d expected %0d", at - s, 26 + WB);
        else pass_cnt++;
        total_cnt++;
        if (last_carry !== {LANES{1'b1}})
            $display("FAIL sub_carry_preset: got %h expected all ones", last_carry);
        else pass_cnt++;
        total_cnt++;
        if (inv_viol != 0) $display("FAIL sub_invert_held: got %0d gaps expected 0", inv_viol);
        else pass_cnt++;
        total_cnt++;
        if (wr_q.size() - w0 != 8 + WB || wr_q[w0 + 7] != 8'h87)
            $display("FAIL sub_writes: got %0d writes last %0h expected %0d last 87",
                     wr_q.size() - w0, wr_q[w0 + 7], 8 + WB);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (res_mem[8'h80 + k] !== {LANES{exp_v[k]}})
                $display("FAIL sub_diff bit%0d: got %h expected %h", k, res_mem[8'h80 + k], {LANES{exp_v[k]}});
            else pass_cnt++;
        end
        @(negedge sys_clk_in);
        sub_expect = 1'b0;
        total_cnt++;
        if (done_cnt - d0 != 1 || invert_b_out !== 1'b0)
            $display("FAIL sub_end: got done %0d invert %b expected 1 and 0", done_cnt - d0, invert_b_out);
        else pass_cnt++;
    endtask

    task automatic test_wait();
        int s, at, r0;
        bit seen;
        r0 = rd_q.size();
        begin_op(1'b0, 6'd2, 8'h20, 8'h28, 8'h30, 64'd1, 64'd1, 5, s);
        wait_done(80, seen, at);
        total_cnt++;
        if (!seen || at != s + 16 + WB)
            $display("FAIL wait_done_cycle: got %0d expected %0d", at - s, 16 + WB);
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() - r0 != 2) $display("FAIL wait_read_count: got %0d expected 2", rd_q.size() - r0);
        else pass_cnt++;
        total_cnt++;
        if (hold_viol != 0) $display("FAIL wait_addr_hold: got %0d changes expected 0", hold_viol);
        else pass_cnt++;
        total_cnt++;
        if (res_mem[8'h30] !== '0 || res_mem[8'h31] !== {LANES{1'b1}})
            $display("FAIL wait_sum: got %h %h expected 0 and all ones", res_mem[8'h30], res_mem[8'h31]);
        else pass_cnt++;
        @(negedge sys_clk_in);
        rd_delay = 1;
    endtask

    task automatic test_wrap();
        int s, at, r0, w0, d0;
        bit seen;
        int exp_rd[4];
        exp_rd = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
        begin_op(1'b0, 6'd4, 8'hFE, 8'h80, 8'h40, 64'd0, 64'd0, 1, s);
        repeat (4) @(negedge sys_clk_in);
        bits_in  = 6'd2;
        start_in = 1'b1;
        @(negedge sys_clk_in);
        start_in = 1'b0;
        wait_done(80, seen, at);
        total_cnt++;
        if (!seen || at != s + 14 + WB)
            $display("FAIL wrap_done_cycle: got %0d expected %0d", at - s, 14 + WB);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (rd_q[r0 + k] != exp_rd[k])
                $display("FAIL wrap_read bit%0d: got %0h expected %0h", k, rd_q[r0 + k], exp_rd[k]);
            else pass_cnt++;
        end
        repeat (6) @(negedge sys_clk_in);
        total_cnt++;
        if (done_cnt - d0 != 1 || wr_q.size() - w0 != 4 + WB || busy_out !== 1'b0)
            $display("FAIL wrap_midstart_ignored: got done %0d writes %0d busy %b expected 1 %0d 0",
                     done_cnt - d0, wr_q.size() - w0, busy_out, 4 + WB);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int s, at, w0, r0, d0;
        bit seen, hit;
        logic [7:0] exp_v;
        w0 = wr_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        begin_op(1'b0, 6'd4, 8'h00, 8'h08, 8'h50, 64'd0, 64'd0, 1, s);
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (wr_en_out && wr_addr_out == 8'h51) begin
                hit = 1'b1;
                break;
            end
            @(negedge sys_clk_in);
        end
        abort_in = 1'b1;
        @(negedge sys_clk_in);
        abort_in = 1'b0;
        total_cnt++;
        if (!hit || busy_out !== 1'b0 || {rd_en_out, wr_en_out, load_carry_out, update_carry_out, done_out} !== '0)
            $display("FAIL abort_stop: got hit %b busy %b expected hit 1 busy 0 strobes 0", hit, busy_out);
        else pass_cnt++;
        repeat (15) @(negedge sys_clk_in);
        total_cnt++;
        if (wr_q.size() - w0 != 2 || rd_q.size() - r0 != 2 || done_cnt != d0)
            $display("FAIL abort_quiet: got writes %0d reads %0d dones %0d expected 2 2 0",
                     wr_q.size() - w0, rd_q.size() - r0, done_cnt - d0);
        else pass_cnt++;

        // Abort together with start in IDLE drops the command.
        bits_in = 6'd4; start_in = 1'b1; abort_in = 1'b1;
        @(negedge sys_clk_in);
        start_in = 1'b0; abort_in = 1'b0;
        repeat (3) @(negedge sys_clk_in);
        total_cnt++;
        if (busy_out !== 1'b0 || wr_q.size() - w0 != 2)
            $display("FAIL abort_start_drop: got busy %b writes %0d expected 0 2", busy_out, wr_q.size() - w0);
        else pass_cnt++;

        // Normal run after abort: 3 + 1 = 4.
        exp_v = 8'd4;
        w0 = wr_q.size(); d0 = done_cnt;
        begin_op(1'b0, 6'd3, 8'h00, 8'h08, 8'h58, 64'd3, 64'd1, 1, s);
        wait_done(80, seen, at);
        total_cnt++;
        if (!seen || at != s + 11 + WB || wr_q.size() - w0 != 3 + WB)
            $display("FAIL abort_rerun: got cycle %0d writes %0d expected %0d %0d",
                     at - s, wr_q.size() - w0, 11 + WB, 3 + WB);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (res_mem[8'h58 + k] !== {LANES{exp_v[k]}})
                $display("FAIL abort_rerun_sum bit%0d: got %h expected %h", k, res_mem[8'h58 + k], {LANES{exp_v[k]}});
            else pass_cnt++;
        end
        @(negedge sys_clk_in);
    endtask

    task automatic test_zero_bits();
        int s, at, w0, r0, l0;
        bit seen;
        w0 = wr_q.size(); r0 = rd_q.size(); l0 = load_cnt;
        begin_op(1'b0, 6'd0, 8'h00, 8'h00, 8'h00, 64'd0, 64'd0, 1, s);
        wait_done(10, seen, at);
        total_cnt++;
        if (!seen || at != s + 1 || busy_out !== 1'b1)
            $display("FAIL zero_done: got cycle %0d busy %b expected 1 and 1", at - s, busy_out);
        else pass_cnt++;
        @(negedge sys_clk_in);
        total_cnt++;
        if (busy_out !== 1'b0 || wr_q.size() != w0 || rd_q.size() != r0 || load_cnt != l0)
            $display("FAIL zero_no_activity: got busy %b wr %0d rd %0d ld %0d expected 0 0 0 0",
                     busy_out, wr_q.size() - w0, rd_q.size() - r0, load_cnt - l0);
        else pass_cnt++;
    endtask

    task automatic test_max_bits();
        int s, at, w0, r0;
        bit seen;
        w0 = wr_q.size(); r0 = rd_q.size();
        begin_op(1'b0, 6'd40, 8'h00, 8'h00, 8'hA0, 64'd0, 64'd0, 1, s);
        wait_done(200, seen, at);
        total_cnt++;
        if (!seen || at != s + 98 + WB)
            $display("FAIL max_done_cycle: got %0d expected %0d", at - s, 98 + WB);
        else pass_cnt++;
        total_cnt++;
        if (wr_q.size() - w0 != 32 + WB || rd_q.size() - r0 != 32 || wr_q[w0 + 31] != 8'hBF)
            $display("FAIL max_clamp: got writes %0d reads %0d last %0h expected %0d 32 bf",
                     wr_q.size() - w0, rd_q.size() - r0, wr_q[w0 + 31], 32 + WB);
        else pass_cnt++;
        total_cnt++;
        if (excl_viol != 0 || upd_viol != 0)
            $display("FAIL strobe_exclusive: got excl %0d upd %0d expected 0 0", excl_viol, upd_viol);
        else pass_cnt++;
        @(negedge sys_clk_in);
    endtask

    task automatic test_reset_mid_op();
        int s, d0;
        d0 = done_cnt;
        begin_op(1'b1, 6'd4, 8'h00, 8'h08, 8'h10, 64'd0, 64'd0, 1, s);
        repeat (3) @(negedge sys_clk_in);
        sys_reset_n_in = 1'b0;
        #1;
        total_cnt++;
        if ({busy_out, done_out, rd_en_out, rd_addr_a_out, rd_addr_b_out, invert_b_out,
             load_carry_out, update_carry_out, carry_out, wr_en_out, wr_addr_out} !== '0)
            $display("FAIL reset_mid_op: got busy %b rd %b wr %b inv %b expected all 0",
                     busy_out, rd_en_out, wr_en_out, invert_b_out);
        else pass_cnt++;
        sub_expect = 1'b0;
        @(negedge sys_clk_in);
        sys_reset_n_in = 1'b1;
        repeat (20) @(negedge sys_clk_in);
        total_cnt++;
        if (done_cnt != d0 || busy_out !== 1'b0)
            $display("FAIL reset_mid_no_done: got dones %0d busy %b expected 0 0", done_cnt - d0, busy_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wait();
        test_wrap();
        test_abort();
        test_zero_bits();
        test_max_bits();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
